// File: rtl/itcm_loader_pkg.sv
// itcm_loader_pkg
//   Shared definitions for the boot-time ITCM program loader: the frame
//   parser state encoding, the default frame start marker and the number
//   of bytes packed into one ITCM word.
package itcm_loader_pkg;

    // Frame parser states, in the order a well-formed frame visits them.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEN0  = 3'd1,
        LEN1  = 3'd2,
        DATA  = 3'd3,
        WRITE = 3'd4,
        CSUM  = 3'd5,
        DONE  = 3'd6,
        ERR   = 3'd7
    } state_e;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;
    localparam int         BYTES_PER_WORD    = 4;

    // The byte stream is stalled only while a word is written or while
    // the result flags of a finished frame are being updated.
    function automatic logic state_accepts_bytes(input state_e s);
        return !(s inside {WRITE, DONE, ERR});
    endfunction

    // A frame is "in progress" from the first length byte up to the checksum.
    function automatic logic state_is_busy(input state_e s);
        return s inside {LEN0, LEN1, DATA, WRITE, CSUM};
    endfunction

endpackage

// File: rtl/itcm_loader.sv
// itcm_loader
//   Boot-time program loader in front of the ITCM write port. Parses a
//   framed byte stream (SYNC, LEN_LO, LEN_HI, 4*LEN data bytes, CSUM),
//   packs data bytes little-endian into 32-bit words, writes them to
//   consecutive word addresses starting at 0 and keeps the core in reset
//   until a frame with a matching XOR checksum has been fully written.
//
// Ports
//   clk           single clock
//   rst_n         asynchronous active-low reset
//   rx_data       received byte
//   rx_valid      rx_data is valid
//   rx_ready      loader accepts a byte this cycle
//   itcm_addr     ITCM word address (registered)
//   itcm_wr_data  ITCM write data (registered)
//   itcm_wr_en    one-cycle ITCM write strobe
//   load_busy     frame in progress (LEN0 .. CSUM)
//   load_done     last frame loaded OK (sticky until next sync)
//   load_err      last frame failed (sticky until next sync)
//   cpu_hold      core reset request, active high
module itcm_loader
    import itcm_loader_pkg::*;
#(
    parameter int         ADDR_WIDTH = 14,
    parameter int         DATA_WIDTH = 32,
    parameter logic [7:0] SYNC_BYTE  = DEFAULT_SYNC_BYTE
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic [ADDR_WIDTH-1:0] itcm_addr,
    output logic [DATA_WIDTH-1:0] itcm_wr_data,
    output logic                  itcm_wr_en,
    output logic                  load_busy,
    output logic                  load_done,
    output logic                  load_err,
    output logic                  cpu_hold
);

    // Largest legal word count; LEN equal to this fills the whole ITCM.
    localparam logic [31:0] MAX_WORDS = 32'd1 << ADDR_WIDTH;
    localparam logic [1:0]  LANE_LAST = 2'(BYTES_PER_WORD - 1);

    state_e                  state_q, state_d;
    logic [7:0]              len_lo_q, len_lo_d;
    logic [ADDR_WIDTH:0]     len_q, len_d;
    // One bit wider than the address so that a full-ITCM frame can count
    // up to 2^ADDR_WIDTH without the index wrapping back to 0.
    logic [ADDR_WIDTH:0]     word_idx_q, word_idx_d;
    logic [1:0]              lane_q, lane_d;
    logic [DATA_WIDTH-1:0]   word_q, word_d;
    logic [7:0]              csum_q, csum_d;

    logic                    rx_ready_q, rx_ready_d;
    logic [ADDR_WIDTH-1:0]   itcm_addr_q, itcm_addr_d;
    logic [DATA_WIDTH-1:0]   itcm_wr_data_q, itcm_wr_data_d;
    logic                    itcm_wr_en_q, itcm_wr_en_d;
    logic                    load_busy_q, load_busy_d;
    logic                    load_done_q, load_done_d;
    logic                    load_err_q, load_err_d;
    logic                    cpu_hold_q, cpu_hold_d;

    logic                    byte_fire;
    logic [31:0]             len_full;
    logic [DATA_WIDTH-1:0]   word_next;

    assign byte_fire = rx_valid && rx_ready_q;

    // Next-state and datapath logic. All outputs are computed here from the
    // next state so that they come straight out of flops.
    always_comb begin
        state_d        = state_q;
        len_lo_d       = len_lo_q;
        len_d          = len_q;
        word_idx_d     = word_idx_q;
        lane_d         = lane_q;
        word_d         = word_q;
        csum_d         = csum_q;
        itcm_addr_d    = itcm_addr_q;
        itcm_wr_data_d = itcm_wr_data_q;
        load_done_d    = load_done_q;
        load_err_d     = load_err_q;
        cpu_hold_d     = cpu_hold_q;
        len_full       = {16'h0000, rx_data, len_lo_q};
        word_next      = word_q;

        unique case (state_q)
            IDLE: begin
                // Anything other than the sync marker is line noise.
                if (byte_fire && rx_data == SYNC_BYTE) begin
                    load_done_d = 1'b0;
                    load_err_d  = 1'b0;
                    cpu_hold_d  = 1'b1;
                    word_idx_d  = '0;
                    csum_d      = '0;
                    lane_d      = '0;
                    state_d     = LEN0;
                end
            end

            LEN0: begin
                if (byte_fire) begin
                    len_lo_d = rx_data;
                    state_d  = LEN1;
                end
            end

            LEN1: begin
                if (byte_fire) begin
                    if (len_full > MAX_WORDS) begin
                        state_d = ERR;
                    end else if (len_full == 32'd0) begin
                        state_d = CSUM;
                    end else begin
                        len_d   = len_full[ADDR_WIDTH:0];
                        lane_d  = '0;
                        state_d = DATA;
                    end
                end
            end

            DATA: begin
                if (byte_fire) begin
                    // Byte k of a word lands in bits [8k+7:8k].
                    word_next[{lane_q, 3'b000} +: 8] = rx_data;
                    word_d = word_next;
                    csum_d = csum_q ^ rx_data;
                    lane_d = lane_q + 2'd1;
                    if (lane_q == LANE_LAST) begin
                        itcm_addr_d    = word_idx_q[ADDR_WIDTH-1:0];
                        itcm_wr_data_d = word_next;
                        state_d        = WRITE;
                    end
                end
            end

            WRITE: begin
                word_idx_d = word_idx_q + 1'b1;
                state_d    = (word_idx_d == len_q) ? CSUM : DATA;
            end

            CSUM: begin
                if (byte_fire) begin
                    state_d = (rx_data == csum_q) ? DONE : ERR;
                end
            end

            DONE: begin
                load_done_d = 1'b1;
                cpu_hold_d  = 1'b0;
                state_d     = IDLE;
            end

            ERR: begin
                load_err_d = 1'b1;
                cpu_hold_d = 1'b1;
                state_d    = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        rx_ready_d   = state_accepts_bytes(state_d);
        load_busy_d  = state_is_busy(state_d);
        itcm_wr_en_d = (state_d == WRITE);
    end

    // Single register bank for the parser state, datapath and outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            len_lo_q       <= '0;
            len_q          <= '0;
            word_idx_q     <= '0;
            lane_q         <= '0;
            word_q         <= '0;
            csum_q         <= '0;
            rx_ready_q     <= 1'b1;
            itcm_addr_q    <= '0;
            itcm_wr_data_q <= '0;
            itcm_wr_en_q   <= 1'b0;
            load_busy_q    <= 1'b0;
            load_done_q    <= 1'b0;
            load_err_q     <= 1'b0;
            cpu_hold_q     <= 1'b1;
        end else begin
            state_q        <= state_d;
            len_lo_q       <= len_lo_d;
            len_q          <= len_d;
            word_idx_q     <= word_idx_d;
            lane_q         <= lane_d;
            word_q         <= word_d;
            csum_q         <= csum_d;
            rx_ready_q     <= rx_ready_d;
            itcm_addr_q    <= itcm_addr_d;
            itcm_wr_data_q <= itcm_wr_data_d;
            itcm_wr_en_q   <= itcm_wr_en_d;
            load_busy_q    <= load_busy_d;
            load_done_q    <= load_done_d;
            load_err_q     <= load_err_d;
            cpu_hold_q     <= cpu_hold_d;
        end
    end

    assign rx_ready     = rx_ready_q;
    assign itcm_addr    = itcm_addr_q;
    assign itcm_wr_data = itcm_wr_data_q;
    assign itcm_wr_en   = itcm_wr_en_q;
    assign load_busy    = load_busy_q;
    assign load_done    = load_done_q;
    assign load_err     = load_err_q;
    assign cpu_hold     = cpu_hold_q;

endmodule
